// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// FSM encoding, parity selectors and frame-length helper.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } tx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic int frame_bits(
      input int   d_width,
      input logic par_en,
      input logic stop2
   );
      return 2 + d_width + int'(par_en) + int'(stop2);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter.
// Head word is visible on rd_data whenever the FIFO is not empty.
module uart_tx_fifo #(
   parameter int D_WIDTH    = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               wr_en,
   input  logic [D_WIDTH-1:0] wr_data,
   input  logic               rd_en,
   output logic [D_WIDTH-1:0] rd_data,
   output logic               full,
   output logic               empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

   logic [D_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;
   logic               do_wr;
   logic               do_rd;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO, baud prescaler, framing FSM.
// Config is latched per frame; frames run back-to-back while queued.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int D_WIDTH     = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int PRESC_WIDTH = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [D_WIDTH-1:0]     P_DATA,
   input  logic                   DATA_VALID,
   output logic                   READY,
   input  logic                   PAR_EN,
   input  logic                   PAR_TYP,
   input  logic                   STOP2,
   input  logic [PRESC_WIDTH-1:0] PRESCALE,
   output logic                   S_DATA,
   output logic                   BUSY,
   output logic                   FIFO_EMPTY
);

   localparam int BW = $clog2(D_WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(D_WIDTH - 1);

   tx_state_t              state;
   logic [D_WIDTH-1:0]     shift;
   logic [BW-1:0]          bit_cnt;
   logic [PRESC_WIDTH-1:0] baud_cnt;
   logic [PRESC_WIDTH-1:0] presc_q;
   logic                   par_en_q;
   logic                   stop2_q;
   logic                   par_bit;
   logic                   s_data_q;
   logic                   busy_q;

   logic               fifo_full;
   logic               fifo_empty;
   logic [D_WIDTH-1:0] rd_data;
   logic               bit_tick;
   logic               frame_end;
   logic               pop;

   uart_tx_fifo #(
      .D_WIDTH    (D_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (DATA_VALID),
      .wr_data (P_DATA),
      .rd_en   (pop),
      .rd_data (rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign READY      = !fifo_full;
   assign FIFO_EMPTY = fifo_empty;
   assign S_DATA     = s_data_q;
   assign BUSY       = busy_q;

   assign bit_tick  = (baud_cnt == '0);
   assign frame_end = bit_tick &&
                      ((state == ST_STOP1 && !stop2_q) ||
                       (state == ST_STOP2));
   // Popping at end-of-frame skips IDLE so queued words follow gap-free
   assign pop = !fifo_empty && (state == ST_IDLE || frame_end);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= ST_IDLE;
         shift    <= '0;
         bit_cnt  <= '0;
         baud_cnt <= '0;
         presc_q  <= '0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
         par_bit  <= 1'b0;
         s_data_q <= 1'b1;
         busy_q   <= 1'b0;
      end else if (pop) begin
         state    <= ST_START;
         shift    <= rd_data;
         par_bit  <= (^rd_data) ^ (PAR_TYP == PAR_ODD);
         par_en_q <= PAR_EN;
         stop2_q  <= STOP2;
         presc_q  <= PRESCALE;
         baud_cnt <= PRESCALE;
         bit_cnt  <= '0;
         s_data_q <= 1'b0;
         busy_q   <= 1'b1;
      end else if (state != ST_IDLE) begin
         if (!bit_tick) begin
            baud_cnt <= baud_cnt - PRESC_WIDTH'(1);
         end else begin
            baud_cnt <= presc_q;
            case (state)
               ST_START: begin
                  state    <= ST_DATA;
                  s_data_q <= shift[0];
                  shift    <= shift >> 1;
                  bit_cnt  <= '0;
               end
               ST_DATA: begin
                  if (bit_cnt == LAST_BIT) begin
                     state    <= par_en_q ? ST_PARITY : ST_STOP1;
                     s_data_q <= par_en_q ? par_bit : 1'b1;
                  end else begin
                     s_data_q <= shift[0];
                     shift    <= shift >> 1;
                     bit_cnt  <= bit_cnt + BW'(1);
                  end
               end
               ST_PARITY: begin
                  state    <= ST_STOP1;
                  s_data_q <= 1'b1;
               end
               ST_STOP1: begin
                  s_data_q <= 1'b1;
                  if (stop2_q) begin
                     state <= ST_STOP2;
                  end else begin
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                  end
               end
               default: begin
                  state    <= ST_IDLE;
                  s_data_q <= 1'b1;
                  busy_q   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered.
// Samples every negedge into history arrays, then checks windows.
module tb_uart_tx_buffered;
   import uart_pkg::*;

   logic       CLK;
   logic       RST;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       READY;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       STOP2;
   logic [7:0] PRESCALE;
   logic       S_DATA;
   logic       BUSY;
   logic       FIFO_EMPTY;

   uart_tx_buffered #(
      .D_WIDTH     (8),
      .FIFO_DEPTH  (4),
      .PRESC_WIDTH (8)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .READY      (READY),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .STOP2      (STOP2),
      .PRESCALE   (PRESCALE),
      .S_DATA     (S_DATA),
      .BUSY       (BUSY),
      .FIFO_EMPTY (FIFO_EMPTY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   logic hist_s [0:8191];
   logic hist_b [0:8191];
   logic hist_e [0:8191];
   logic hist_r [0:8191];

   task automatic chk(input string tag,
                      input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      hist_s[cyc] = S_DATA;
      hist_b[cyc] = BUSY;
      hist_e[cyc] = FIFO_EMPTY;
      hist_r[cyc] = READY;
      cyc++;
   endtask

   task automatic push(input logic [7:0] w);
      P_DATA     = w;
      DATA_VALID = 1'b1;
      tick();
   endtask

   function automatic logic [127:0] line_win(input int lo, input int len);
      logic [127:0] r;
      r = '0;
      for (int j = 0; j < len; j++) r[j] = hist_s[lo+j];
      return r;
   endfunction

   function automatic int zeros_s(input int lo, input int n);
      int c;
      c = 0;
      for (int j = 0; j < n; j++) if (hist_s[lo+j] == 1'b0) c++;
      return c;
   endfunction

   function automatic int ones_b(input int lo, input int n);
      int c;
      c = 0;
      for (int j = 0; j < n; j++) if (hist_b[lo+j] == 1'b1) c++;
      return c;
   endfunction

   // Expected line value per clock for one frame
   function automatic logic [127:0] mk_frame(input logic [7:0] w,
                                             input logic pe,
                                             input logic pt,
                                             input logic s2,
                                             input int p,
                                             output int len);
      logic [15:0]  b;
      logic [127:0] r;
      int nb;
      int k;
      int ones;
      b  = '0;
      nb = 0;
      b[nb] = 1'b0; nb++;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         b[nb] = w[i]; nb++;
         if (w[i]) ones++;
      end
      if (pe) begin
         b[nb] = (ones % 2 == 1) ? ~pt : pt; nb++;
      end
      b[nb] = 1'b1; nb++;
      if (s2) begin b[nb] = 1'b1; nb++; end
      r = '0;
      k = 0;
      for (int i = 0; i < nb; i++)
         for (int j = 0; j <= p; j++) begin
            r[k] = b[i]; k++;
         end
      len = k;
      return r;
   endfunction

   logic [127:0] ex;
   logic [127:0] ex2;
   int           ln;
   int           ln2;
   int           k;
   int           k2;
   logic [7:0]   w4 [6];

   initial begin
      RST = 1'b0; P_DATA = '0; DATA_VALID = 1'b0;
      PAR_EN = 1'b0; PAR_TYP = PAR_EVEN; STOP2 = 1'b0; PRESCALE = '0;
      tick(); tick();
      chk("rst_sdata", 128'(S_DATA), 128'(1));
      chk("rst_busy",  128'(BUSY),   128'(0));
      chk("rst_ready", 128'(READY),  128'(1));
      chk("rst_empty", 128'(FIFO_EMPTY), 128'(1));
      RST = 1'b1;
      repeat (3) tick();

      // 1: 8'h3F, even parity, one bit per clock
      PAR_EN = 1'b1; PAR_TYP = PAR_EVEN; STOP2 = 1'b0; PRESCALE = 8'd0;
      k = cyc;
      push(8'h3F);
      DATA_VALID = 1'b0;
      repeat (20) tick();
      chk("t1_frame", line_win(k+1, 11), 128'(11'b10001111110));
      chk("t1_busy", 128'(ones_b(k, 16)), 128'(11));

      // 2: 8'h55, odd parity, two stops, 4 clocks per bit
      PAR_TYP = PAR_ODD; STOP2 = 1'b1; PRESCALE = 8'd3;
      k = cyc;
      push(8'h55);
      DATA_VALID = 1'b0;
      repeat (60) tick();
      ex = mk_frame(8'h55, 1'b1, 1'b1, 1'b1, 3, ln);
      chk("t2_len", 128'(ln), 128'(48));
      chk("t2_frame", line_win(k+1, 48), ex);
      chk("t2_busy", 128'(ones_b(k, 56)), 128'(48));

      // 3: two frames back-to-back, no parity
      PAR_EN = 1'b0; STOP2 = 1'b0; PRESCALE = 8'd1;
      k = cyc;
      push(8'h55);
      push(8'h11);
      DATA_VALID = 1'b0;
      repeat (50) tick();
      ex  = mk_frame(8'h55, 1'b0, 1'b0, 1'b0, 1, ln);
      ex2 = mk_frame(8'h11, 1'b0, 1'b0, 1'b0, 1, ln2);
      chk("t3_frame1", line_win(k+1, 20), ex);
      chk("t3_frame2", line_win(k+21, 20), ex2);
      chk("t3_busy", 128'(ones_b(k, 46)), 128'(40));
      chk("t3_empty_before", 128'(hist_e[k+20]), 128'(0));
      chk("t3_empty_at_pop2", 128'(hist_e[k+21]), 128'(1));

      // 4: overfill the FIFO, sixth word is dropped
      PRESCALE = 8'd7;
      w4[0] = 8'hA1; w4[1] = 8'hB2; w4[2] = 8'hC3;
      w4[3] = 8'hD4; w4[4] = 8'hE5; w4[5] = 8'hF6;
      k = cyc;
      for (int i = 0; i < 6; i++) push(w4[i]);
      DATA_VALID = 1'b0;
      repeat (520) tick();
      chk("t4_ready_4th", 128'(hist_r[k+3]), 128'(1));
      chk("t4_ready_5th", 128'(hist_r[k+4]), 128'(0));
      for (int i = 0; i < 5; i++) begin
         ex = mk_frame(w4[i], 1'b0, 1'b0, 1'b0, 7, ln);
         chk($sformatf("t4_frame%0d", i), line_win(k+1+80*i, 80), ex);
      end
      chk("t4_idle_line", 128'(zeros_s(k+401, 100)), 128'(0));
      chk("t4_idle_busy", 128'(ones_b(k+401, 100)), 128'(0));

      // 5: config change mid-frame only affects the next frame
      PAR_EN = 1'b1; PAR_TYP = PAR_EVEN; STOP2 = 1'b0; PRESCALE = 8'd2;
      k = cyc;
      push(8'h96);
      DATA_VALID = 1'b0;
      repeat (5) tick();
      PRESCALE = 8'd4; PAR_TYP = PAR_ODD;
      push(8'h3C);
      DATA_VALID = 1'b0;
      repeat (100) tick();
      ex  = mk_frame(8'h96, 1'b1, 1'b0, 1'b0, 2, ln);
      ex2 = mk_frame(8'h3C, 1'b1, 1'b1, 1'b0, 4, ln2);
      chk("t5_frame_old", line_win(k+1, 33), ex);
      chk("t5_frame_new", line_win(k+34, 55), ex2);

      // 6: reset in the middle of a data bit with 3 queued
      PAR_EN = 1'b0; PAR_TYP = PAR_EVEN; PRESCALE = 8'd3;
      k = cyc;
      push(8'h00);
      push(8'hAA);
      push(8'hBB);
      push(8'hCC);
      DATA_VALID = 1'b0;
      repeat (6) tick();
      chk("t6_pre_sdata", 128'(S_DATA), 128'(0));
      chk("t6_pre_busy", 128'(BUSY), 128'(1));
      chk("t6_pre_empty", 128'(FIFO_EMPTY), 128'(0));
      RST = 1'b0;
      #1;
      chk("t6_rst_sdata", 128'(S_DATA), 128'(1));
      chk("t6_rst_busy", 128'(BUSY), 128'(0));
      chk("t6_rst_empty", 128'(FIFO_EMPTY), 128'(1));
      chk("t6_rst_ready", 128'(READY), 128'(1));
      tick(); tick();
      RST = 1'b1;
      k2 = cyc;
      repeat (60) tick();
      chk("t6_quiet_line", 128'(zeros_s(k2, 60)), 128'(0));
      chk("t6_quiet_busy", 128'(ones_b(k2, 60)), 128'(0));
      k = cyc;
      push(8'h5A);
      DATA_VALID = 1'b0;
      repeat (50) tick();
      ex = mk_frame(8'h5A, 1'b0, 1'b0, 1'b0, 3, ln);
      chk("t6_after_frame", line_win(k+1, 40), ex);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
